// File: rtl/rat_pc_unit.sv
// RAT CPU program-counter unit: registered PC with selectable load source,
// increment, and an on-block hardware return-address stack for CALL/RET/interrupts.
module rat_pc_unit #(
    parameter int                ADDR_W       = 10,
    parameter int                STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] ISR_VECTOR   = {ADDR_W{1'b1}},
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    localparam int               DEPTH_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               PC_LD,
    input  logic               PC_INC,
    input  logic [1:0]         PC_MUX_SEL,
    input  logic [ADDR_W-1:0]  FROM_IMMED,
    input  logic               RS_PUSH,
    input  logic               RS_POP,
    output logic [ADDR_W-1:0]  PC_COUNT,
    output logic [ADDR_W-1:0]  RS_TOP,
    output logic [DEPTH_W-1:0] RS_DEPTH,
    output logic               RS_EMPTY,
    output logic               RS_FULL,
    output logic               RS_ERR
);

    localparam int PTR_W = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        SEL_IMMED  = 2'b00,
        SEL_RS_TOP = 2'b01,
        SEL_ISR    = 2'b10,
        SEL_RESET  = 2'b11
    } pc_sel_e;

    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q,   err_d;
    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

    logic               empty, full;
    logic [PTR_W-1:0]   top_ptr, wr_ptr;
    logic               wr_en;
    logic [ADDR_W-1:0]  top_val;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign top_ptr = PTR_W'(depth_q - DEPTH_W'(1));

    // Top of stack comes from registered state only, so RET sees the pre-edge value.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first; otherwise a latch is inferred.
        top_val = '0;
        if (!empty) begin
            top_val = stack_mem[top_ptr];
        end
    end

    // A push+pop on a non-empty stack overwrites the top; otherwise write the next free slot.
    always_comb begin
        wr_ptr = PTR_W'(depth_q);
        if (RS_POP && !empty) begin
            wr_ptr = top_ptr;
        end
        wr_en = RST_N && RS_PUSH && (!full || RS_POP);
    end

    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        unique case ({RS_PUSH, RS_POP})
            2'b10: begin
                if (!full) depth_d = depth_q + DEPTH_W'(1);
                else       err_d   = 1'b1;
            end
            2'b01: begin
                if (!empty) depth_d = depth_q - DEPTH_W'(1);
                else        err_d   = 1'b1;
            end
            2'b11: begin
                if (empty) depth_d = DEPTH_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (PC_LD) begin
            unique case (pc_sel_e'(PC_MUX_SEL))
                SEL_IMMED:  pc_d = FROM_IMMED;
                SEL_RS_TOP: pc_d = top_val;
                SEL_ISR:    pc_d = ISR_VECTOR;
                SEL_RESET:  pc_d = RESET_VECTOR;
                default:    pc_d = pc_q;
            endcase
        end else if (PC_INC) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
        if (!RST_N) begin
            pc_q    <= RESET_VECTOR;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the stack array has no reset; depth alone defines which entries are valid.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            stack_mem[wr_ptr] <= pc_q;
        end
    end

    assign PC_COUNT = pc_q;
    assign RS_TOP   = top_val;
    assign RS_DEPTH = depth_q;
    assign RS_EMPTY = empty;
    assign RS_FULL  = full;
    assign RS_ERR   = err_q;

endmodule

// File: tb/tb_rat_pc_unit.sv
// Scoreboard bench for rat_pc_unit: directed vectors push expected state,
// a negedge monitor pops and compares once the corresponding edge has passed.
module tb_rat_pc_unit;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       PC_LD, PC_INC, RS_PUSH, RS_POP;
    logic [1:0] PC_MUX_SEL;
    logic [9:0] FROM_IMMED;
    logic [9:0] PC_COUNT, RS_TOP;
    logic [3:0] RS_DEPTH;
    logic       RS_EMPTY, RS_FULL, RS_ERR;

    rat_pc_unit dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .PC_LD      (PC_LD),
        .PC_INC     (PC_INC),
        .PC_MUX_SEL (PC_MUX_SEL),
        .FROM_IMMED (FROM_IMMED),
        .RS_PUSH    (RS_PUSH),
        .RS_POP     (RS_POP),
        .PC_COUNT   (PC_COUNT),
        .RS_TOP     (RS_TOP),
        .RS_DEPTH   (RS_DEPTH),
        .RS_EMPTY   (RS_EMPTY),
        .RS_FULL    (RS_FULL),
        .RS_ERR     (RS_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        int         due;
        logic [9:0] pc;
        logic [9:0] top;
        logic [3:0] depth;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   cycle      = 0;
    int   vectors    = 0;
    int   miscompares = 0;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", name, field, act, exp);
            miscompares++;
        end
    endtask

    // Monitor: compare every expectation whose edge has already occurred.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].due <= cycle) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            check(e.name, "PC_COUNT", 32'(PC_COUNT), 32'(e.pc));
            check(e.name, "RS_TOP",   32'(RS_TOP),   32'(e.top));
            check(e.name, "RS_DEPTH", 32'(RS_DEPTH), 32'(e.depth));
            check(e.name, "RS_EMPTY", 32'(RS_EMPTY), 32'(e.depth == 4'd0));
            check(e.name, "RS_FULL",  32'(RS_FULL),  32'(e.depth == 4'd8));
            check(e.name, "RS_ERR",   32'(RS_ERR),   32'(e.err));
        end
    end

    task automatic apply(input string name, input logic rst_n_v, input logic ld, input logic inc,
                         input logic [1:0] sel, input logic [9:0] imm,
                         input logic push, input logic pop,
                         input logic [9:0] e_pc, input logic [9:0] e_top,
                         input logic [3:0] e_depth, input logic e_err);
        exp_t e;
        RST_N      = rst_n_v;
        PC_LD      = ld;
        PC_INC     = inc;
        PC_MUX_SEL = sel;
        FROM_IMMED = imm;
        RS_PUSH    = push;
        RS_POP     = pop;
        e.name  = name;
        e.due   = cycle + 1;
        e.pc    = e_pc;
        e.top   = e_top;
        e.depth = e_depth;
        e.err   = e_err;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; PC_LD = 1'b0; PC_INC = 1'b0; PC_MUX_SEL = 2'b00;
        FROM_IMMED = '0; RS_PUSH = 1'b0; RS_POP = 1'b0;
        @(posedge CLK);
        #1;
        //     name          rst ld inc sel    imm     psh pop  pc      top     d  err
        apply("reset",        0, 0, 0, 2'b00, 10'h000, 0, 0, 10'h000, 10'h000, 0, 0);
        apply("inc1",         1, 0, 1, 2'b00, 10'h000, 0, 0, 10'h001, 10'h000, 0, 0);
        apply("inc2",         1, 0, 1, 2'b00, 10'h000, 0, 0, 10'h002, 10'h000, 0, 0);
        apply("inc3",         1, 0, 1, 2'b00, 10'h000, 0, 0, 10'h003, 10'h000, 0, 0);
        apply("ld_beats_inc", 1, 1, 1, 2'b00, 10'h3FE, 0, 0, 10'h3FE, 10'h000, 0, 0);
        apply("inc_3ff",      1, 0, 1, 2'b00, 10'h000, 0, 0, 10'h3FF, 10'h000, 0, 0);
        apply("inc_wrap",     1, 0, 1, 2'b00, 10'h000, 0, 0, 10'h000, 10'h000, 0, 0);
        apply("hold",         1, 0, 0, 2'b00, 10'h155, 0, 0, 10'h000, 10'h000, 0, 0);
        apply("ld_010",       1, 1, 0, 2'b00, 10'h010, 0, 0, 10'h010, 10'h000, 0, 0);
        apply("call",         1, 1, 0, 2'b00, 10'h120, 1, 0, 10'h120, 10'h010, 1, 0);
        apply("ret",          1, 1, 0, 2'b01, 10'h000, 0, 1, 10'h010, 10'h000, 0, 0);
        apply("ld_top_empty", 1, 1, 0, 2'b01, 10'h2AB, 0, 0, 10'h000, 10'h000, 0, 0);
        // Fill: push PCs 1..9 while incrementing.
        apply("ld_001",       1, 1, 0, 2'b00, 10'h001, 0, 0, 10'h001, 10'h000, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            apply($sformatf("push%0d", i), 1, 0, 1, 2'b00, 10'h000, 1, 0,
                  10'(i + 1), 10'(i), 4'(i), 0);
        end
        apply("push9_ovf",    1, 0, 1, 2'b00, 10'h000, 1, 0, 10'h00A, 10'h008, 8, 1);
        for (int i = 1; i <= 8; i++) begin
            apply($sformatf("pop%0d", i), 1, 0, 0, 2'b00, 10'h000, 0, 1,
                  10'h00A, 10'(8 - i), 4'(8 - i), 1);
        end
        apply("pop9_udf",     1, 0, 0, 2'b00, 10'h000, 0, 1, 10'h00A, 10'h000, 0, 1);
        apply("reset2",       0, 1, 1, 2'b00, 10'h3C3, 1, 0, 10'h000, 10'h000, 0, 0);
        // Simultaneous push+pop, non-empty then empty.
        apply("ld_044",       1, 1, 0, 2'b00, 10'h044, 0, 0, 10'h044, 10'h000, 0, 0);
        apply("call_055",     1, 1, 0, 2'b00, 10'h055, 1, 0, 10'h055, 10'h044, 1, 0);
        apply("call_0aa",     1, 1, 0, 2'b00, 10'h0AA, 1, 0, 10'h0AA, 10'h055, 2, 0);
        apply("pushpop_d2",   1, 0, 0, 2'b00, 10'h000, 1, 1, 10'h0AA, 10'h0AA, 2, 0);
        apply("pop_to_1",     1, 0, 0, 2'b00, 10'h000, 0, 1, 10'h0AA, 10'h044, 1, 0);
        apply("pop_to_0",     1, 0, 0, 2'b00, 10'h000, 0, 1, 10'h0AA, 10'h000, 0, 0);
        apply("pushpop_empty",1, 0, 0, 2'b00, 10'h000, 1, 1, 10'h0AA, 10'h0AA, 1, 0);
        // Interrupt entry, then reset mid-sequence.
        apply("ld_033",       1, 1, 0, 2'b00, 10'h033, 0, 0, 10'h033, 10'h0AA, 1, 0);
        apply("irq",          1, 1, 0, 2'b10, 10'h000, 1, 0, 10'h3FF, 10'h033, 2, 0);
        apply("reset_mid",    0, 0, 1, 2'b00, 10'h000, 1, 0, 10'h000, 10'h000, 0, 0);
        apply("idle",         1, 0, 0, 2'b00, 10'h000, 0, 0, 10'h000, 10'h000, 0, 0);
        apply("inc_after",    1, 0, 1, 2'b00, 10'h000, 0, 0, 10'h001, 10'h000, 0, 0);
        apply("ld_reset_vec", 1, 1, 0, 2'b11, 10'h1F0, 0, 0, 10'h000, 10'h000, 0, 0);
        RST_N = 1'b1; PC_LD = 1'b0; PC_INC = 1'b0; RS_PUSH = 1'b0; RS_POP = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations not checked, expected 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
